// File: rtl/calc_pkg.sv
// Shared key codes, ALU opcodes and controller state encoding for the calculator.
package calc_pkg;

    localparam logic [4:0] KEY_ADD = 5'b10000;
    localparam logic [4:0] KEY_SUB = 5'b10001;
    localparam logic [4:0] KEY_MUL = 5'b10010;
    localparam logic [4:0] KEY_DIV = 5'b10011;
    localparam logic [4:0] KEY_EQ  = 5'b10100;
    localparam logic [4:0] KEY_AC  = 5'b10101;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        A_ENTRY,
        OP_PEND,
        B_ENTRY,
        ALU_REQ,
        ALU_WAIT,
        RESULT,
        ERROR
    } ctrl_state_e;

    // Operator that follows a chained result (e.g. the '-' in "5 x 2 -").
    typedef struct packed {
        logic    vld;
        alu_op_e op;
    } chain_t;

    function automatic logic is_digit(input logic [4:0] k);
        return !k[4];
    endfunction

    // Operator codes share the 100 prefix; the low two bits are the opcode.
    function automatic logic is_operator(input logic [4:0] k);
        return k[4:2] == 3'b100;
    endfunction

    function automatic logic is_eq(input logic [4:0] k);
        return k == KEY_EQ;
    endfunction

    function automatic logic is_ac(input logic [4:0] k);
        return k == KEY_AC;
    endfunction

endpackage

// File: rtl/calc_controller_if.sv
// Key, arithmetic-unit and display signals of the calculator controller.
interface calc_controller_if #(
    parameter int WIDTH = 16
);
    import calc_pkg::*;

    logic [4:0]       i_key_data;
    logic             i_key_valid;
    logic             o_key_ready;

    logic [WIDTH-1:0] o_alu_a;
    logic [WIDTH-1:0] o_alu_b;
    alu_op_e          o_alu_op;
    logic             o_alu_valid;
    logic             i_alu_ready;
    logic             i_alu_done;
    logic [WIDTH-1:0] i_alu_result;
    logic             i_alu_error;

    logic [WIDTH-1:0] o_disp_value;
    logic             o_disp_error;

    // Controller side.
    modport master (
        input  i_key_data, i_key_valid,
        output o_key_ready,
        output o_alu_a, o_alu_b, o_alu_op, o_alu_valid,
        input  i_alu_ready, i_alu_done, i_alu_result, i_alu_error,
        output o_disp_value, o_disp_error
    );

    // Keypad / arithmetic unit / display side.
    modport slave (
        output i_key_data, i_key_valid,
        input  o_key_ready,
        input  o_alu_a, o_alu_b, o_alu_op, o_alu_valid,
        output i_alu_ready, i_alu_done, i_alu_result, i_alu_error,
        input  o_disp_value, o_disp_error
    );

endinterface

// File: rtl/calc_operand_reg.sv
// Hex operand register: clear, load a single digit, shift a digit in, or load a full value.
// The shift is refused when the top nibble is already occupied, so digits never wrap out.
module calc_operand_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld_digit,
    input  logic             sh_digit,
    input  logic             ld_value,
    input  logic [3:0]       digit,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nxt
);

    // Next value, exposed so the controller can display it on the same edge it is stored.
    always_comb begin
        nxt = q;
        if (clr)
            nxt = '0;
        else if (ld_value)
            nxt = value;
        else if (ld_digit)
            nxt = {{(WIDTH-4){1'b0}}, digit};
        else if (sh_digit && (q[WIDTH-1 -: 4] == 4'h0))
            nxt = {q[WIDTH-5:0], digit};
    end

    // Operand storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else
            q <= nxt;
    end

endmodule

// File: rtl/calc_controller.sv
// Calculator sequencer: assembles operands from key codes, issues ALU requests,
// collects results (including chained operators) and drives the display.
module calc_controller
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic              clk,
    input logic              rst_n,
    calc_controller_if.master bus
);

    ctrl_state_e      state;
    alu_op_e          op;
    chain_t           chain;
    logic             alu_valid;
    logic [WIDTH-1:0] disp_value;
    logic             disp_error;

    // Result strobe that arrived on the request handshake cycle, replayed in ALU_WAIT.
    logic             done_pend;
    logic [WIDTH-1:0] pend_result;
    logic             pend_error;

    logic [4:0]       key;
    logic             key_ready;
    logic             key_fire;
    logic             done_any;
    logic             done_err;
    logic [WIDTH-1:0] done_res;

    logic             a_clr, a_ld_digit, a_sh_digit, a_ld_value;
    logic             b_clr, b_ld_digit, b_sh_digit;
    logic [WIDTH-1:0] a_q, a_nxt, b_q, b_nxt;

    assign key       = bus.i_key_data;
    assign key_ready = (state != ALU_REQ) && (state != ALU_WAIT);
    assign key_fire  = bus.i_key_valid && key_ready;
    assign done_any  = (state == ALU_WAIT) && (done_pend || bus.i_alu_done);
    assign done_err  = done_pend ? pend_error  : bus.i_alu_error;
    assign done_res  = done_pend ? pend_result : bus.i_alu_result;

    // Operand register controls decoded from the accepted key or the returning result.
    always_comb begin
        a_clr      = 1'b0;
        a_ld_digit = 1'b0;
        a_sh_digit = 1'b0;
        a_ld_value = 1'b0;
        b_clr      = 1'b0;
        b_ld_digit = 1'b0;
        b_sh_digit = 1'b0;
        if (key_fire) begin
            if (is_ac(key)) begin
                a_clr = 1'b1;
                b_clr = 1'b1;
            end else if (is_digit(key)) begin
                case (state)
                    A_ENTRY: a_sh_digit = 1'b1;
                    OP_PEND: b_ld_digit = 1'b1;
                    B_ENTRY: b_sh_digit = 1'b1;
                    RESULT:  a_ld_digit = 1'b1;
                    default: ;
                endcase
            end
        end
        if (done_any && !done_err)
            a_ld_value = 1'b1;
    end

    calc_operand_reg #(.WIDTH(WIDTH)) u_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (a_clr),
        .ld_digit (a_ld_digit),
        .sh_digit (a_sh_digit),
        .ld_value (a_ld_value),
        .digit    (key[3:0]),
        .value    (done_res),
        .q        (a_q),
        .nxt      (a_nxt)
    );

    calc_operand_reg #(.WIDTH(WIDTH)) u_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (b_clr),
        .ld_digit (b_ld_digit),
        .sh_digit (b_sh_digit),
        .ld_value (1'b0),
        .digit    (key[3:0]),
        .value    ({WIDTH{1'b0}}),
        .q        (b_q),
        .nxt      (b_nxt)
    );

    // Sequencer FSM with registered request, opcode and display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= A_ENTRY;
            op          <= OP_ADD;
            chain       <= '0;
            alu_valid   <= 1'b0;
            disp_value  <= '0;
            disp_error  <= 1'b0;
            done_pend   <= 1'b0;
            pend_result <= '0;
            pend_error  <= 1'b0;
        end else if (key_fire && is_ac(key)) begin
            disp_value <= '0;
            disp_error <= 1'b0;
            state      <= A_ENTRY;
        end else begin
            case (state)
                A_ENTRY: if (key_fire) begin
                    if (is_digit(key)) begin
                        disp_value <= a_nxt;
                    end else if (is_operator(key)) begin
                        op    <= alu_op_e'(key[1:0]);
                        state <= OP_PEND;
                    end
                end
                OP_PEND: if (key_fire) begin
                    if (is_digit(key)) begin
                        disp_value <= b_nxt;
                        state      <= B_ENTRY;
                    end else if (is_operator(key)) begin
                        op <= alu_op_e'(key[1:0]);
                    end
                end
                B_ENTRY: if (key_fire) begin
                    if (is_digit(key)) begin
                        disp_value <= b_nxt;
                    end else if (is_operator(key)) begin
                        chain     <= '{vld: 1'b1, op: alu_op_e'(key[1:0])};
                        alu_valid <= 1'b1;
                        state     <= ALU_REQ;
                    end else if (is_eq(key)) begin
                        chain     <= '0;
                        alu_valid <= 1'b1;
                        state     <= ALU_REQ;
                    end
                end
                ALU_REQ: if (bus.i_alu_ready) begin
                    alu_valid   <= 1'b0;
                    state       <= ALU_WAIT;
                    done_pend   <= bus.i_alu_done;
                    pend_result <= bus.i_alu_result;
                    pend_error  <= bus.i_alu_error;
                end
                ALU_WAIT: if (done_any) begin
                    done_pend <= 1'b0;
                    if (done_err) begin
                        disp_error <= 1'b1;
                        state      <= ERROR;
                    end else begin
                        disp_value <= done_res;
                        if (chain.vld) begin
                            op    <= chain.op;
                            state <= OP_PEND;
                        end else begin
                            state <= RESULT;
                        end
                    end
                end
                RESULT: if (key_fire) begin
                    if (is_digit(key)) begin
                        disp_value <= a_nxt;
                        state      <= A_ENTRY;
                    end else if (is_operator(key)) begin
                        op    <= alu_op_e'(key[1:0]);
                        state <= OP_PEND;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_key_ready  = key_ready;
    assign bus.o_alu_a      = a_q;
    assign bus.o_alu_b      = b_q;
    assign bus.o_alu_op     = op;
    assign bus.o_alu_valid  = alu_valid;
    assign bus.o_disp_value = disp_value;
    assign bus.o_disp_error = disp_error;

endmodule

// File: doc/calc_controller.md
Name: calc_controller

Overview:
- Central sequencer of the calculator. Consumes 5-bit key codes from the keypad scanner over a valid/ready handshake.
- Builds hex operands A and B, issues operations to the arithmetic unit over a second valid/ready handshake, and collects results. Supports chained operations.
- Drives the registered value and error flag shown by the display driver.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 8.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_key_data  in  5  key code: 0_dddd = hex digit d; 10_000 +, 10_001 −, 10_010 ×, 10_011 ÷, 10_100 =, 10_101 AC
- i_key_valid  in  1  key code valid
- o_key_ready  out  1  controller accepts a key this cycle
- o_alu_a  out  WIDTH  operand A
- o_alu_b  out  WIDTH  operand B
- o_alu_op  out  2  00 add, 01 sub, 10 mul, 11 div
- o_alu_valid  out  1  operation request
- i_alu_ready  in  1  arithmetic unit accepts request
- i_alu_done  in  1  one-cycle result strobe
- i_alu_result  in  WIDTH  result, valid with i_alu_done
- i_alu_error  in  1  divide-by-zero/overflow, valid with i_alu_done
- o_disp_value  out  WIDTH  value to display
- o_disp_error  out  1  display error indication

Behaviour:
- Reset is asynchronous, active-low; clock is clk. On reset: state A_ENTRY; a, b, op, chain registers = 0; o_alu_valid = 0; o_disp_value = 0; o_disp_error = 0.
- A reset asserted mid-operation aborts everything. A later i_alu_done is ignored unless the state is ALU_WAIT.
- A key is accepted on a cycle with i_key_valid && o_key_ready.
- o_key_ready = 1 in A_ENTRY, OP_PEND, B_ENTRY, RESULT, ERROR. It is 0 in ALU_REQ and ALU_WAIT.
- Illegal codes (10_110, 10_111, 11_xxx) are consumed and ignored.
- Digit shift rule: reg ← {reg[WIDTH-5:0], d} only if reg[WIDTH-1:WIDTH-4] == 0. Otherwise the digit is consumed and ignored (no wrap).
- AC in any ready state: a = b = 0, o_disp_error = 0, display 0, → A_ENTRY.
- A_ENTRY:
  - digit: shift into a; display a.
  - operator (+ − × ÷): op ← code[1:0]; → OP_PEND.
  - =: ignored.
- OP_PEND:
  - operator: replaces op.
  - digit: b ← d; display b; → B_ENTRY.
  - =: ignored.
- B_ENTRY:
  - digit: shift into b; display b.
  - operator: chain ← {1, code[1:0]}; → ALU_REQ.
  - =: chain ← 0; → ALU_REQ.
- ALU_REQ:
  - o_alu_valid = 1 (registered; asserted the cycle after the accepting key edge).
  - a, b, op held stable while valid && !ready.
  - On i_alu_ready: → ALU_WAIT; o_alu_valid drops next cycle.
- ALU_WAIT: waits indefinitely for i_alu_done.
  - i_alu_error = 1: o_disp_error ← 1; → ERROR.
  - Otherwise: a ← result; display result. If chain valid: op ← chain op, → OP_PEND. Else → RESULT.
  - i_alu_done in the same cycle as the i_alu_ready handshake is legal and is processed after a one-cycle delay; it must not be lost. Store it in a pending flag.
- RESULT:
  - digit: a ← d; display a; → A_ENTRY (new calculation).
  - operator: op ← code; → OP_PEND (continues from result).
  - =: ignored.
- ERROR: all keys except AC are consumed and ignored. Display value stays frozen.
- Arithmetic width rules are the arithmetic unit's concern. The controller never modifies i_alu_result.

Decomposition:
- calc_pkg holds:
  - key code localparams: KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV, KEY_EQ, KEY_AC.
  - typedef alu_op_e (2-bit).
  - typedef ctrl_state_e: A_ENTRY, OP_PEND, B_ENTRY, ALU_REQ, ALU_WAIT, RESULT, ERROR.
  - key decode function (is_digit, is_operator).
- The scanner (button_reader) and the arithmetic unit import the same key and op constants.
- Sub-module calc_operand_reg (WIDTH; clear, load-digit, shift-digit, load-value; overflow-guarded shift) is instantiated twice, for A and B.

Test Plan:
- Keys 1,2,+,3,= → o_alu_valid with a=0x0012, b=0x0003, op=00. Bench returns 0x0015 → o_disp_value=0x0015, state RESULT, o_key_ready=1.
- Keys 1,2,3,4,5 → a=0x1234. Fifth digit ignored; o_key_ready stays 1 throughout.
- Keys 5,×,2,− → request mul 5×2. Result 0x000A → OP_PEND, op=01. Then 3,= → request a=0x000A, b=0x0003, op=01.
- Keys 8,÷,0,= with i_alu_error=1 → o_disp_error=1. Keys 7 and + are accepted but cause no change. AC → error 0, display 0, A_ENTRY.
- Hold i_alu_ready=0 for 5 cycles during a request → o_alu_valid, a, b, op stable and o_key_ready=0. Pressed keys stay pending at the scanner and are accepted after the result.
- Assert rst_n=0 during ALU_WAIT, then strobe i_alu_done → all outputs at reset values; strobe ignored.
